// File: rtl/rvv_defs.sv
// ----------------------------------------------------------------------------
// rvv_defs : shared RVV load/store address-generator types
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rvv_defs;

  typedef enum logic [1:0] {
    UNIT_STRIDE = 2'd0,
    STRIDED     = 2'd1,
    INDEXED     = 2'd2,
    MODE_RSVD   = 2'd3
  } access_type_t;

  typedef enum logic [1:0] {
    EEW8  = 2'd0,
    EEW16 = 2'd1,
    EEW32 = 2'd2,
    EEW64 = 2'd3
  } eew_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GEN  = 2'd1,
    IDX  = 2'd2
  } agu_state_t;

  localparam int VLEN = 256;

endpackage

`default_nettype wire

// File: rtl/agu_stream_lane_calc.sv
// ----------------------------------------------------------------------------
// agu_lane_calc : combinational per-beat lane addresses, mask and last flag
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module agu_lane_calc #(
  parameter int ADDR_W = 64,
  parameter int LANES  = 2,
  parameter int CNT_W  = 9
) (
  input  logic                    i_indexed,
  input  logic [ADDR_W-1:0]       i_cur,
  input  logic [ADDR_W-1:0]       i_stride,
  input  logic [ADDR_W-1:0]       i_base,
  input  logic [LANES*ADDR_W-1:0] i_idx,
  input  logic [CNT_W-1:0]        i_elem,
  input  logic [CNT_W-1:0]        i_vl,
  output logic [LANES*ADDR_W-1:0] o_addr,
  output logic [LANES-1:0]        o_mask,
  output logic                    o_last
);

  logic [LANES-1:0][ADDR_W-1:0] w_seq;
  logic [ADDR_W-1:0]            w_acc;

  // Lane i of a strided beat is cur + i*stride, built as a running sum.
  always_comb begin
    w_seq = '0;
    w_acc = i_cur;
    for (int i = 0; i < LANES; i++) begin
      w_seq[i] = w_acc;
      w_acc    = w_acc + i_stride;
    end
  end

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [CNT_W:0]    w_e;
    logic [ADDR_W-1:0] w_raw;

    assign w_e   = {1'b0, i_elem} + (CNT_W+1)'(gi);
    assign w_raw = i_indexed ? (i_base + i_idx[gi*ADDR_W +: ADDR_W]) : w_seq[gi];
    assign o_mask[gi]                   = (w_e < {1'b0, i_vl});
    assign o_addr[gi*ADDR_W +: ADDR_W]  = o_mask[gi] ? w_raw : '0;
  end

  assign o_last = (({1'b0, i_elem} + (CNT_W+1)'(LANES)) >= {1'b0, i_vl});

endmodule

`default_nettype wire

// File: rtl/agu_stream.sv
// ----------------------------------------------------------------------------
// agu_stream : RVV unit/strided/indexed address streamer, LANES addrs per beat
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module agu_stream
  import rvv_defs::*;
#(
  parameter  int ADDR_W = 64,
  parameter  int LANES  = 2,
  parameter  int MAX_VL = 256,
  localparam int CNT_W  = $clog2(MAX_VL+1)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_mode,
  input  logic [1:0]              req_eew,
  input  logic [ADDR_W-1:0]       req_base,
  input  logic [ADDR_W-1:0]       req_stride,
  input  logic [CNT_W-1:0]        req_vl,
  input  logic                    idx_valid,
  output logic                    idx_ready,
  input  logic [LANES*ADDR_W-1:0] idx_data,
  output logic                    addr_valid,
  input  logic                    addr_ready,
  output logic [LANES*ADDR_W-1:0] addr_out,
  output logic [LANES-1:0]        addr_mask,
  output logic                    addr_last,
  output logic                    busy,
  output logic                    err
);

  localparam int LG_L = $clog2(LANES);

  agu_state_t              r_state;
  logic [ADDR_W-1:0]       r_base;
  logic [ADDR_W-1:0]       r_stride;
  logic [ADDR_W-1:0]       r_cur;
  logic [CNT_W-1:0]        r_vl;
  logic [CNT_W-1:0]        r_elem;
  logic                    r_idx_done;
  logic                    r_valid;
  logic [LANES*ADDR_W-1:0] r_addr;
  logic [LANES-1:0]        r_mask;
  logic                    r_last;
  logic                    r_err;

  access_type_t            w_mode;
  logic                    w_idle;
  logic [ADDR_W-1:0]       w_req_stride;
  logic                    w_addr_fire;
  logic                    w_idx_ready;
  logic                    w_idx_fire;
  logic [ADDR_W-1:0]       w_c_cur;
  logic [ADDR_W-1:0]       w_c_stride;
  logic [ADDR_W-1:0]       w_c_base;
  logic [CNT_W-1:0]        w_c_elem;
  logic [CNT_W-1:0]        w_c_vl;
  logic [LANES*ADDR_W-1:0] w_c_addr;
  logic [LANES-1:0]        w_c_mask;
  logic                    w_c_last;

  assign w_mode       = access_type_t'(req_mode);
  assign w_idle       = (r_state == IDLE);
  assign w_req_stride = (w_mode == UNIT_STRIDE) ? (ADDR_W'(1) << req_eew) : req_stride;
  assign w_addr_fire  = r_valid && addr_ready;
  assign w_idx_ready  = (r_state == IDX) && !r_idx_done && (!r_valid || addr_ready);
  assign w_idx_fire   = idx_valid && w_idx_ready;

  // In IDLE the first beat is computed straight from the request inputs.
  assign w_c_cur    = w_idle ? req_base     : r_cur;
  assign w_c_stride = w_idle ? w_req_stride : r_stride;
  assign w_c_base   = w_idle ? req_base     : r_base;
  assign w_c_elem   = w_idle ? '0           : r_elem;
  assign w_c_vl     = w_idle ? req_vl       : r_vl;

  agu_lane_calc #(
    .ADDR_W (ADDR_W),
    .LANES  (LANES),
    .CNT_W  (CNT_W)
  ) u_lane_calc (
    .i_indexed (r_state == IDX),
    .i_cur     (w_c_cur),
    .i_stride  (w_c_stride),
    .i_base    (w_c_base),
    .i_idx     (idx_data),
    .i_elem    (w_c_elem),
    .i_vl      (w_c_vl),
    .o_addr    (w_c_addr),
    .o_mask    (w_c_mask),
    .o_last    (w_c_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_base     <= '0;
      r_stride   <= '0;
      r_cur      <= '0;
      r_vl       <= '0;
      r_elem     <= '0;
      r_idx_done <= 1'b0;
      r_valid    <= 1'b0;
      r_addr     <= '0;
      r_mask     <= '0;
      r_last     <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_base   <= req_base;
            r_stride <= w_req_stride;
            r_vl     <= req_vl;
            if (w_mode == MODE_RSVD) begin
              r_err <= 1'b1;
            end else if (req_vl != '0) begin
              if (w_mode == INDEXED) begin
                r_state    <= IDX;
                r_elem     <= '0;
                r_idx_done <= 1'b0;
              end else begin
                r_state <= GEN;
                r_valid <= 1'b1;
                r_addr  <= w_c_addr;
                r_mask  <= w_c_mask;
                r_last  <= w_c_last;
                r_cur   <= req_base + (w_req_stride << LG_L);
                r_elem  <= CNT_W'(LANES);
              end
            end
          end
        end
        GEN: begin
          if (w_addr_fire) begin
            if (r_last) begin
              r_valid <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_addr <= w_c_addr;
              r_mask <= w_c_mask;
              r_last <= w_c_last;
              r_cur  <= r_cur + (r_stride << LG_L);
              r_elem <= r_elem + CNT_W'(LANES);
            end
          end
        end
        IDX: begin
          if (w_idx_fire) begin
            r_valid    <= 1'b1;
            r_addr     <= w_c_addr;
            r_mask     <= w_c_mask;
            r_last     <= w_c_last;
            r_elem     <= r_elem + CNT_W'(LANES);
            r_idx_done <= w_c_last;
          end else if (w_addr_fire) begin
            r_valid <= 1'b0;
            if (r_last) begin
              r_state <= IDLE;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready  = w_idle;
  assign idx_ready  = w_idx_ready;
  assign addr_valid = r_valid;
  assign addr_out   = r_addr;
  assign addr_mask  = r_mask;
  assign addr_last  = r_last;
  assign busy       = !w_idle;
  assign err        = r_err;

endmodule

`default_nettype wire

// File: tb/tb_agu_stream.sv
// ----------------------------------------------------------------------------
// tb_agu_stream : randomized scoreboard bench for agu_stream
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_agu_stream;
  import rvv_defs::*;

  localparam int A  = 64;
  localparam int L  = 2;
  localparam int MV = 256;
  localparam int CW = $clog2(MV+1);

  logic           clk = 1'b0;
  logic           rst_n;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_mode;
  logic [1:0]     req_eew;
  logic [A-1:0]   req_base;
  logic [A-1:0]   req_stride;
  logic [CW-1:0]  req_vl;
  logic           idx_valid;
  logic           idx_ready;
  logic [L*A-1:0] idx_data;
  logic           addr_valid;
  logic           addr_ready = 1'b0;
  logic [L*A-1:0] addr_out;
  logic [L-1:0]   addr_mask;
  logic           addr_last;
  logic           busy;
  logic           err;

  typedef struct {
    logic [L*A-1:0] addr;
    logic [L-1:0]   mask;
    logic           last;
  } beat_t;

  beat_t exp_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;
  int    stall_n = 0;
  bit    in_rst  = 1'b0;

  agu_stream #(.ADDR_W(A), .LANES(L), .MAX_VL(MV)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_mode   (req_mode),
    .req_eew    (req_eew),
    .req_base   (req_base),
    .req_stride (req_stride),
    .req_vl     (req_vl),
    .idx_valid  (idx_valid),
    .idx_ready  (idx_ready),
    .idx_data   (idx_data),
    .addr_valid (addr_valid),
    .addr_ready (addr_ready),
    .addr_out   (addr_out),
    .addr_mask  (addr_mask),
    .addr_last  (addr_last),
    .busy       (busy),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // Reference: element e of a unit/strided request lives at base + e*stride.
  function automatic void push_gen(input logic [1:0] mode, input logic [1:0] eew,
                                   input logic [A-1:0] base, input logic [A-1:0] stride,
                                   input int vl);
    logic [A-1:0] st;
    int nb;
    beat_t b;
    st = (mode == 2'd0) ? (64'd1 << eew) : stride;
    nb = (vl + L - 1) / L;
    for (int k = 0; k < nb; k++) begin
      b.addr = '0;
      b.mask = '0;
      for (int i = 0; i < L; i++) begin
        int e = k * L + i;
        if (e < vl) begin
          b.mask[i]       = 1'b1;
          b.addr[i*A +: A] = base + A'(e) * st;
        end
      end
      b.last = (k == nb - 1);
      exp_q.push_back(b);
    end
  endfunction

  function automatic beat_t idx_beat(input logic [A-1:0] base, input int vl, input int k,
                                     input logic [L*A-1:0] data);
    beat_t b;
    b.addr = '0;
    b.mask = '0;
    for (int i = 0; i < L; i++) begin
      int e = k * L + i;
      if (e < vl) begin
        b.mask[i]        = 1'b1;
        b.addr[i*A +: A] = base + data[i*A +: A];
      end
    end
    b.last = ((k + 1) * L >= vl);
    return b;
  endfunction

  // Monitor: drives addr_ready, pops the scoreboard on each handshake and
  // checks that a stalled beat stays put.
  initial begin
    bit    have_held;
    beat_t held;
    beat_t b;
    have_held = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_n > 0) begin
        addr_ready = 1'b0;
        stall_n--;
      end else begin
        addr_ready = ($urandom_range(0, 3) != 0);
      end
      if (in_rst) begin
        have_held = 1'b0;
      end else begin
        if (have_held) begin
          chk("valid_held", addr_valid, 1'b1);
          chk("hold_stable", {addr_out, addr_mask, addr_last}, {held.addr, held.mask, held.last});
        end
        if (addr_valid && addr_ready) begin
          have_held = 1'b0;
          if (exp_q.size() == 0) begin
            fail_now("unexpected_beat");
          end else begin
            b = exp_q.pop_front();
            chk("beat", {addr_out, addr_mask, addr_last}, {b.addr, b.mask, b.last});
          end
        end else if (addr_valid) begin
          have_held = 1'b1;
          held.addr = addr_out;
          held.mask = addr_mask;
          held.last = addr_last;
        end else begin
          have_held = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1);
  end

  task automatic wait_idle();
    int t = 0;
    while (!(req_ready && exp_q.size() == 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    if (!(req_ready && exp_q.size() == 0)) fail_now("wait_idle_timeout");
  endtask

  task automatic send_req(input logic [1:0] mode, input logic [1:0] eew,
                          input logic [A-1:0] base, input logic [A-1:0] stride, input int vl);
    req_mode   = mode;
    req_eew    = eew;
    req_base   = base;
    req_stride = stride;
    req_vl     = CW'(vl);
    req_valid  = 1'b1;
    if (mode == 2'd0 || mode == 2'd1) push_gen(mode, eew, base, stride, vl);
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    // Scramble the fields so a design that fails to capture them shows up.
    req_mode   = 2'($urandom);
    req_eew    = 2'($urandom);
    req_base   = {$urandom, $urandom};
    req_stride = {$urandom, $urandom};
    req_vl     = CW'($urandom);
  endtask

  task automatic send_idx_beat(input logic [A-1:0] base, input int vl, input int k,
                               input logic [L*A-1:0] data);
    bit ok = 1'b0;
    idx_valid = 1'b1;
    idx_data  = data;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      #1;
      if (idx_ready) begin
        exp_q.push_back(idx_beat(base, vl, k, data));
        @(posedge clk);
        #1;
        ok = 1'b1;
        break;
      end
    end
    idx_valid = 1'b0;
    idx_data  = {$urandom, $urandom, $urandom, $urandom};
    if (!ok) fail_now("idx_timeout");
  endtask

  task automatic send_idx_rand(input logic [A-1:0] base, input int vl);
    int nb = (vl + L - 1) / L;
    for (int k = 0; k < nb; k++) begin
      int gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) @(posedge clk);
      #1;
      send_idx_beat(base, vl, k, {$urandom, $urandom, $urandom, $urandom});
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_mode   = 2'd0;
    req_eew    = 2'd0;
    req_base   = '0;
    req_stride = '0;
    req_vl     = '0;
    idx_valid  = 1'b0;
    idx_data   = '0;
    in_rst     = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_addr_valid", addr_valid, 1'b0);
    chk("rst_outputs", {addr_out, addr_mask, addr_last}, '0);
    chk("rst_busy_err_idx", {busy, err, idx_ready}, 3'b000);
    chk("rst_req_ready", req_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_rst = 1'b0;

    // Unit e64, vl=3: three elements over two beats
    wait_idle();
    send_req(2'd0, 2'd3, 64'h1000, '0, 3);

    // Strided -16, vl=2: single beat one cycle after the handshake
    wait_idle();
    send_req(2'd1, 2'd0, 64'h2000, -64'sd16, 2);
    chk("latency_gen", addr_valid, 1'b1);
    chk("gen_busy_idx", {busy, idx_ready}, 2'b10);

    // Indexed base 0x100 with offsets {0x8, 0x40}
    wait_idle();
    send_req(2'd2, 2'd0, 64'h100, '0, 2);
    send_idx_beat(64'h100, 2, 0, {64'h40, 64'h8});
    chk("latency_idx", addr_valid, 1'b1);

    // Address wrap across 2^64
    wait_idle();
    send_req(2'd0, 2'd3, 64'hFFFF_FFFF_FFFF_FFF8, '0, 2);

    // Three-cycle stall mid-stream
    wait_idle();
    send_req(2'd0, 2'd0, 64'h4000, '0, 12);
    @(posedge clk);
    stall_n = 3;

    // Reset while GEN is streaming
    wait_idle();
    send_req(2'd1, 2'd2, 64'h8000, 64'd24, 40);
    repeat (3) @(negedge clk);
    in_rst = 1'b1;
    rst_n  = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_addr_valid", addr_valid, 1'b0);
    chk("midrst_req_ready", {req_ready, busy}, 2'b10);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    in_rst = 1'b0;

    // vl=0: no beats, stays ready
    wait_idle();
    send_req(2'd0, 2'd1, 64'h5000, '0, 0);
    chk("vl0_state", {req_ready, addr_valid, busy}, 3'b100);
    @(posedge clk);
    #1;
    chk("vl0_later", {req_ready, addr_valid}, 2'b10);

    // Reserved mode: one-cycle err pulse, no beats
    wait_idle();
    send_req(2'd3, 2'd0, 64'h6000, 64'd8, 5);
    chk("rsvd_err", {err, addr_valid, busy}, 3'b100);
    @(posedge clk);
    #1;
    chk("rsvd_err_clear", {err, addr_valid, req_ready}, 3'b001);

    for (int r = 0; r < 40; r++) begin
      logic [1:0]   mode;
      logic [1:0]   eew;
      logic [A-1:0] base;
      logic [A-1:0] stride;
      int           vl;
      int           s;
      mode = 2'($urandom_range(0, 2));
      eew  = 2'($urandom_range(0, 3));
      base = {$urandom, $urandom};
      s    = $urandom_range(0, 256) - 128;
      stride = ($urandom_range(0, 1) != 0) ? {$urandom, $urandom} : A'(s);
      vl   = ($urandom_range(0, 9) == 0) ? MV : $urandom_range(0, 40);
      wait_idle();
      send_req(mode, eew, base, stride, vl);
      if (mode == 2'd2) send_idx_rand(base, vl);
    end

    wait_idle();
    repeat (4) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    chk("final_idle", {req_ready, busy, addr_valid}, 3'b100);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
